fifo_to_axis: RTL

Unpacker and AXI4-Stream master for the SRAM packet path. It reads 201-bit packed words and per-packet 128-bit tuser entries from first-word-fall-through FIFOs in the memory-side clock domain. It reassembles 256-bit beats from the packed words and drives them to the output port lookup as AXI4-Stream. Every 4 packed words yield 3 beats.

---
 rtl/fifo_axis_pkg.sv | 40 ++++
 rtl/fifo_to_axis_if.sv | 23 ++
 rtl/axis_out_reg.sv | 48 ++++
 rtl/fifo_to_axis.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fifo_axis_pkg.sv
// fifo_axis_pkg: shared constants, packed-word field positions, the unpacker
// state enum and the byte-count to tkeep decoder used by fifo_to_axis.
package fifo_axis_pkg;

  // Widths of the packed word, its payload and the output beat
  localparam int PACKED_W  = 201;
  localparam int PAYLOAD_W = 192;
  localparam int BEAT_W    = 256;
  localparam int KEEP_W    = BEAT_W / 8;
  localparam int TUSER_W   = 128;
  // A payload is three 64-bit segments; beats are stitched on these boundaries
  localparam int SEG_W     = 64;

  // Packed-word field positions
  localparam int F_VALID      = 0;
  localparam int F_LAST       = 1;
  localparam int F_PHASE_LO   = 2;
  localparam int F_PHASE_HI   = 3;
  localparam int F_CNT_LO     = 4;
  localparam int F_CNT_HI     = 8;
  localparam int F_PAYLOAD_LO = 9;
  localparam int F_PAYLOAD_HI = 200;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BODY = 2'd1,
    S_DROP = 2'd2
  } state_t;

  // Byte count 0 means a full 32-byte beat; otherwise the low cnt bytes are valid
  function automatic logic [KEEP_W-1:0] cnt_to_keep(input logic [4:0] cnt);
    logic [KEEP_W-1:0] keep;
    keep = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      keep[i] = (cnt == 5'd0) || (i < int'(cnt));
    end
    return keep;
  endfunction

endpackage

// File: rtl/fifo_to_axis_if.sv
// fifo_to_axis_if: AXI4-Stream bundle for the unpacker output port.
interface fifo_to_axis_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [DATA_W/8-1:0] tstrb;
  logic [USER_W-1:0]   tuser;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tkeep, tstrb, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tstrb, tuser, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_out_reg.sv
// axis_out_reg: single-entry AXI4-Stream output register. A new beat may be
// loaded while the register is empty or while its current beat is being taken,
// so back-to-back beats flow without a bubble.
module axis_out_reg #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic [USER_W-1:0]   in_user,
  input  logic                in_last,
  output logic                free,
  fifo_to_axis_if.master      m_axis
);

  assign free         = ~m_axis.tvalid | m_axis.tready;
  assign m_axis.tstrb = m_axis.tkeep;

  // Beat fields change only on load, so they stay stable under back-pressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis.tdata <= '0;
      m_axis.tkeep <= '0;
      m_axis.tuser <= '0;
      m_axis.tlast <= 1'b0;
    end else if (load) begin
      m_axis.tdata <= in_data;
      m_axis.tkeep <= in_keep;
      m_axis.tuser <= in_user;
      m_axis.tlast <= in_last;
    end
  end

  // Valid flag: set on load, cleared once the beat is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis.tvalid <= 1'b0;
    end else if (load) begin
      m_axis.tvalid <= 1'b1;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_to_axis.sv
// fifo_to_axis: unpacks 201-bit packed words from FWFT FIFOs into 256-bit
// AXI4-Stream beats (4 words -> 3 beats) with per-packet tuser.
// Optional feature macro: FIFO_AXIS_PHASE_CHECK_EN -- check each word's phase
// field against the expected phase, flag err_phase and drop the packet.
module fifo_to_axis
  import fifo_axis_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = BEAT_W,
  parameter int C_M_AXIS_TUSER_WIDTH = TUSER_W,
  parameter int PACKED_WIDTH         = PACKED_W,
  parameter int PAYLOAD_WIDTH        = PAYLOAD_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [PACKED_WIDTH-1:0]         fifo_dout,
  input  logic                            fifo_empty,
  output logic                            fifo_rd_en,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_dout,
  input  logic                            tuser_empty,
  output logic                            tuser_rd_en,
  fifo_to_axis_if.master                  m_axis,
  output logic [31:0]                     output_beat_cnt,
  output logic [31:0]                     output_pkt_cnt,
  output logic                            err_phase
);

  state_t                           state_reg, state_next;
  logic [1:0]                       phase_reg, phase_next;
  logic [PAYLOAD_WIDTH-1:0]         residual_reg, residual_next;

  logic                             w_valid, w_last;
  logic [1:0]                       w_phase;
  logic [4:0]                       w_cnt;
  logic [PAYLOAD_WIDTH-1:0]         payload;

  logic                             out_free;
  logic                             dropping, mismatch;
  logic                             produce, pop, load;
  logic [C_M_AXIS_DATA_WIDTH-1:0]   beat_data;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] beat_keep;

  assign w_valid = fifo_dout[F_VALID];
  assign w_last  = fifo_dout[F_LAST];
  assign w_phase = fifo_dout[F_PHASE_HI:F_PHASE_LO];
  assign w_cnt   = fifo_dout[F_CNT_HI:F_CNT_LO];
  assign payload = fifo_dout[F_PAYLOAD_HI:F_PAYLOAD_LO];

`ifdef FIFO_AXIS_PHASE_CHECK_EN
  assign dropping = (state_reg == S_DROP);
  assign mismatch = w_valid & ~dropping & (w_phase != phase_reg);

  // Sticky phase error, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_phase <= 1'b0;
    end else if (pop && mismatch) begin
      err_phase <= 1'b1;
    end
  end
`else
  // The phase field is ignored; the expected-phase counter alone drives decoding
  logic unused_phase;
  assign unused_phase = ^w_phase;
  assign dropping     = 1'b0;
  assign mismatch     = 1'b0;
  assign err_phase    = 1'b0;
`endif

  // A word produces a beat when it completes one: a last word or phase 1..3.
  // Such words also need a tuser entry and room in the output register;
  // everything else (filler, phase-0 body words, dropped words) pops freely.
  assign produce     = w_valid & ~dropping & ~mismatch & (w_last | (phase_reg != 2'd0));
  assign pop         = ~fifo_empty & (~produce | (~tuser_empty & out_free));
  assign load        = pop & produce;
  assign fifo_rd_en  = pop;
  assign tuser_rd_en = load & w_last;

  // Stitch the beat from the residual and the current payload
  always_comb begin
    beat_data = '0;
    case (phase_reg)
      2'd0:    beat_data = {{(C_M_AXIS_DATA_WIDTH-PAYLOAD_WIDTH){1'b0}}, payload};
      2'd1:    beat_data = {payload[SEG_W-1:0], residual_reg};
      2'd2:    beat_data = {payload[2*SEG_W-1:0], residual_reg[2*SEG_W-1:0]};
      default: beat_data = {payload, residual_reg[SEG_W-1:0]};
    endcase
  end

  assign beat_keep = w_last ? cnt_to_keep(w_cnt) : '1;

  // Next state, expected phase and residual for each popped valid word
  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    residual_next = residual_reg;
    if (pop && w_valid) begin
      if (dropping) begin
        if (w_last) begin
          state_next    = S_IDLE;
          phase_next    = 2'd0;
          residual_next = '0;
        end
      end else if (mismatch) begin
        phase_next    = 2'd0;
        residual_next = '0;
        state_next    = w_last ? S_IDLE : S_DROP;
      end else if (w_last) begin
        state_next    = S_IDLE;
        phase_next    = 2'd0;
        residual_next = '0;
      end else begin
        state_next = S_BODY;
        phase_next = phase_reg + 2'd1;
        case (phase_reg)
          2'd0:    residual_next = payload;
          2'd1:    residual_next[2*SEG_W-1:0] = payload[PAYLOAD_WIDTH-1:SEG_W];
          2'd2:    residual_next[SEG_W-1:0] = payload[PAYLOAD_WIDTH-1:2*SEG_W];
          default: residual_next = '0;
        endcase
      end
    end
  end

  // State, expected phase and residual registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      phase_reg    <= 2'd0;
      residual_reg <= '0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      residual_reg <= residual_next;
    end
  end

  // Accepted-beat and accepted-packet counters, wrapping modulo 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      output_beat_cnt <= '0;
      output_pkt_cnt  <= '0;
    end else if (m_axis.tvalid && m_axis.tready) begin
      output_beat_cnt <= output_beat_cnt + 32'd1;
      if (m_axis.tlast) begin
        output_pkt_cnt <= output_pkt_cnt + 32'd1;
      end
    end
  end

  axis_out_reg #(
    .DATA_W (C_M_AXIS_DATA_WIDTH),
    .USER_W (C_M_AXIS_TUSER_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .in_data (beat_data),
    .in_keep (beat_keep),
    .in_user (tuser_dout),
    .in_last (w_last),
    .free    (out_free),
    .m_axis  (m_axis)
  );

endmodule
